// File: rtl/sobel_pipe_if.sv
// sobel_pipe_if -- stream bundle for the sobel_pipe edge detector.
//
// Groups every data, sideband and handshake signal of the block.
//   input side : win_i, valid_i, ready_o, mode_i, thresh_i, bin_en_i, user_i
//   output side: pix_o, user_o, valid_o, ready_i (+ dir_o)
// Modports:
//   master - the environment: drives the input side and ready_i
//   slave  - the sobel_pipe block itself
// Macro SOBEL_DIR_EN adds the dir_o gradient-direction signal.

interface sobel_pipe_if #(
    parameter int PIX_W = 8
);
    logic [9*PIX_W-1:0] win_i;
    logic               valid_i;
    logic               ready_o;
    logic [1:0]         mode_i;
    logic [PIX_W+2:0]   thresh_i;
    logic               bin_en_i;
    logic [1:0]         user_i;
    logic [PIX_W-1:0]   pix_o;
    logic [1:0]         user_o;
    logic               valid_o;
    logic               ready_i;
`ifdef SOBEL_DIR_EN
    logic [1:0]         dir_o;

    modport master (
        output win_i, valid_i, mode_i, thresh_i, bin_en_i, user_i, ready_i,
        input  ready_o, pix_o, user_o, valid_o, dir_o
    );

    modport slave (
        input  win_i, valid_i, mode_i, thresh_i, bin_en_i, user_i, ready_i,
        output ready_o, pix_o, user_o, valid_o, dir_o
    );
`else
    modport master (
        output win_i, valid_i, mode_i, thresh_i, bin_en_i, user_i, ready_i,
        input  ready_o, pix_o, user_o, valid_o
    );

    modport slave (
        input  win_i, valid_i, mode_i, thresh_i, bin_en_i, user_i, ready_i,
        output ready_o, pix_o, user_o, valid_o
    );
`endif
endinterface

// File: rtl/sobel_pipe.sv
// sobel_pipe -- 4-stage Sobel edge-magnitude pipeline with valid/ready flow.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - sobel_pipe_if.slave: 3x3 window (d0 at LSBs, row-major), per-pixel
//          mode/threshold/binarise/sideband, edge pixel out, handshakes.
// Stages:
//   1 - positive/negative half-sums of the horizontal and vertical kernels
//   2 - absolute gradients (and their signs when direction is enabled)
//   3 - magnitude per captured mode
//   4 - threshold / binarise / saturate into the output register
// Macro SOBEL_DIR_EN adds dir_o (coarse gradient direction, aligned to pix_o).
//
// One enable moves the whole pipe: it advances whenever the output register is
// empty or being drained, so a stall freezes every stage including bubbles.

module sobel_pipe #(
    parameter int PIX_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    sobel_pipe_if.slave bus
);
    localparam int SW = PIX_W + 2;
    localparam int MW = PIX_W + 3;

    logic en;

    logic [SW-1:0] d [9];
    logic [SW-1:0] gx_p_c, gx_n_c, gy_p_c, gy_n_c;

    logic          v1;
    logic [SW-1:0] gx_p1, gx_n1, gy_p1, gy_n1;
    logic [1:0]    mode1;
    logic [MW-1:0] thresh1;
    logic          bin1;
    logic [1:0]    user1;

    logic          v2;
    logic [SW-1:0] ax2, ay2;
    logic [1:0]    mode2;
    logic [MW-1:0] thresh2;
    logic          bin2;
    logic [1:0]    user2;

    logic          v3;
    logic [MW-1:0] mag_c;
    logic [MW-1:0] mag3;
    logic [MW-1:0] thresh3;
    logic          bin3;
    logic [1:0]    user3;

    logic             valid_r;
    logic [PIX_W-1:0] pix_c;
    logic [PIX_W-1:0] pix_r;
    logic [1:0]       user_r;

`ifdef SOBEL_DIR_EN
    logic       sx2, sy2;
    logic [1:0] dir_c;
    logic [1:0] dir3;
    logic [1:0] dir_r;
`endif

    assign en          = ~valid_r | bus.ready_i;
    assign bus.ready_o = en & ~rst;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            d[i] = SW'(bus.win_i[i*PIX_W +: PIX_W]);
        end
    end

    // Widened to PIX_W+2 so 4*(2^PIX_W-1) cannot overflow.
    assign gx_p_c = d[6] + (d[3] << 1) + d[0];
    assign gx_n_c = d[8] + (d[5] << 1) + d[2];
    assign gy_p_c = d[0] + (d[1] << 1) + d[2];
    assign gy_n_c = d[6] + (d[7] << 1) + d[8];

    always_comb begin
        mag_c = '0;
        case (mode2)
            2'b00:   mag_c = MW'(ax2) + MW'(ay2);
            2'b01:   mag_c = (ax2 >= ay2) ? MW'(ax2) : MW'(ay2);
            2'b10:   mag_c = MW'(ax2);
            default: mag_c = MW'(ay2);
        endcase
    end

    always_comb begin
        pix_c = '0;
        if (mag3 >= thresh3) begin
            pix_c = '1;
        end else if (bin3) begin
            pix_c = '0;
        end else if (|mag3[MW-1:PIX_W]) begin
            pix_c = '1;
        end else begin
            pix_c = mag3[PIX_W-1:0];
        end
    end

`ifdef SOBEL_DIR_EN
    // Shift-by-one on the right side gives the "twice the other" compare
    // without a multiplier; one extra bit keeps both sides exact.
    always_comb begin
        dir_c = 2'b11;
        if ({1'b0, ax2} >= {ay2, 1'b0}) begin
            dir_c = 2'b00;
        end else if ({1'b0, ay2} >= {ax2, 1'b0}) begin
            dir_c = 2'b01;
        end else if (sx2 == sy2) begin
            dir_c = 2'b10;
        end else begin
            dir_c = 2'b11;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            valid_r <= 1'b0;
            pix_r   <= '0;
            user_r  <= '0;
`ifdef SOBEL_DIR_EN
            dir_r   <= '0;
`endif
        end else if (en) begin
            v1      <= bus.valid_i;
            gx_p1   <= gx_p_c;
            gx_n1   <= gx_n_c;
            gy_p1   <= gy_p_c;
            gy_n1   <= gy_n_c;
            mode1   <= bus.mode_i;
            thresh1 <= bus.thresh_i;
            bin1    <= bus.bin_en_i;
            user1   <= bus.user_i;

            v2      <= v1;
            ax2     <= (gx_p1 >= gx_n1) ? gx_p1 - gx_n1 : gx_n1 - gx_p1;
            ay2     <= (gy_p1 >= gy_n1) ? gy_p1 - gy_n1 : gy_n1 - gy_p1;
            mode2   <= mode1;
            thresh2 <= thresh1;
            bin2    <= bin1;
            user2   <= user1;
`ifdef SOBEL_DIR_EN
            sx2     <= (gx_p1 < gx_n1);
            sy2     <= (gy_p1 < gy_n1);
`endif

            v3      <= v2;
            mag3    <= mag_c;
            thresh3 <= thresh2;
            bin3    <= bin2;
            user3   <= user2;
`ifdef SOBEL_DIR_EN
            dir3    <= dir_c;
`endif

            valid_r <= v3;
            pix_r   <= pix_c;
            user_r  <= user3;
`ifdef SOBEL_DIR_EN
            dir_r   <= dir3;
`endif
        end
    end

    assign bus.valid_o = valid_r;
    assign bus.pix_o   = pix_r;
    assign bus.user_o  = user_r;
`ifdef SOBEL_DIR_EN
    assign bus.dir_o   = dir_r;
`endif

endmodule

// File: tb/tb_sobel_pipe.sv
// Testbench for sobel_pipe: directed cases plus randomized traffic with
// random bubbles and backpressure, scored against a plain-arithmetic model.

module tb_sobel_pipe;
    localparam int PIX_W = 8;
    localparam int TW    = PIX_W + 3;
    localparam int PMAX  = (1 << PIX_W) - 1;

    typedef struct {
        int pix;
        int user;
        int dir;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sobel_pipe_if #(.PIX_W(PIX_W)) bus();

    sobel_pipe #(.PIX_W(PIX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   n_push   = 0;
    int   n_pop    = 0;
    bit   lat_chk  = 1'b0;
    bit   bp_rand  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: Sobel gradients as signed integers, then mode/threshold rules.
    function automatic exp_t model(input logic [9*PIX_W-1:0] w, input logic [1:0] mode,
                                   input logic [TW-1:0] th, input logic bin,
                                   input logic [1:0] user);
        exp_t e;
        int dv[9];
        int gx, gy, ax, ay, mag;
        for (int i = 0; i < 9; i++) dv[i] = int'(w[i*PIX_W +: PIX_W]);
        gx = (dv[2] + 2*dv[5] + dv[8]) - (dv[0] + 2*dv[3] + dv[6]);
        gy = (dv[6] + 2*dv[7] + dv[8]) - (dv[0] + 2*dv[1] + dv[2]);
        ax = (gx < 0) ? -gx : gx;
        ay = (gy < 0) ? -gy : gy;
        case (mode)
            2'b00:   mag = ax + ay;
            2'b01:   mag = (ax > ay) ? ax : ay;
            2'b10:   mag = ax;
            default: mag = ay;
        endcase
        if (mag >= int'(th))  e.pix = PMAX;
        else if (bin)         e.pix = 0;
        else if (mag > PMAX)  e.pix = PMAX;
        else                  e.pix = mag;
        if (ax >= 2*ay)                e.dir = 0;
        else if (ay >= 2*ax)           e.dir = 1;
        else if ((gx > 0) == (gy > 0)) e.dir = 2;
        else                           e.dir = 3;
        e.user = int'(user);
        e.cyc  = 0;
        return e;
    endfunction

    // Scoreboard push at acceptance.
    always @(negedge clk) begin : acc_proc
        exp_t e;
        if (!rst && bus.valid_i && bus.ready_o) begin
            e = model(bus.win_i, bus.mode_i, bus.thresh_i, bus.bin_en_i, bus.user_i);
            e.cyc = cyc;
            q.push_back(e);
            n_push++;
        end
    end

    // Monitor: pop/compare on output transfers, check hold behaviour on stalls.
    logic             hold_prev = 1'b0;
    logic [PIX_W-1:0] hold_pix;
    logic [1:0]       hold_user;
    always @(negedge clk) begin : mon_proc
        exp_t e;
        if (rst) begin
            hold_prev <= 1'b0;
        end else begin
            if (hold_prev) begin
                check("stall_valid", int'(bus.valid_o), 1);
                check("stall_pix",   int'(bus.pix_o),   int'(hold_pix));
                check("stall_user",  int'(bus.user_o),  int'(hold_user));
            end
            if (bus.valid_o && !bus.ready_i)
                check("stall_ready_o", int'(bus.ready_o), 0);
            if (bus.valid_o && bus.ready_i) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out: got pix %0d expected no output", bus.pix_o);
                end else begin
                    e = q.pop_front();
                    n_pop++;
                    check("pix",  int'(bus.pix_o),  e.pix);
                    check("user", int'(bus.user_o), e.user);
`ifdef SOBEL_DIR_EN
                    check("dir",  int'(bus.dir_o),  e.dir);
`endif
                    // Presented in cycle a, visible in cycle a+4.
                    if (lat_chk && !hold_prev) check("latency", cyc - e.cyc, 4);
                end
            end
            hold_prev <= bus.valid_o & ~bus.ready_i;
            hold_pix  <= bus.pix_o;
            hold_user <= bus.user_o;
        end
    end

    always @(posedge clk) begin
        #1;
        if (bp_rand) bus.ready_i = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [9*PIX_W-1:0] w, input logic [1:0] m,
                        input logic [TW-1:0] th, input logic b, input logic [1:0] u);
        int n = 0;
        bus.win_i    = w;
        bus.mode_i   = m;
        bus.thresh_i = th;
        bus.bin_en_i = b;
        bus.user_i   = u;
        bus.valid_i  = 1'b1;
        @(negedge clk);
        while (!bus.ready_o && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (n >= 500) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got ready_o 0 expected 1 within 500 cycles");
        end
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || bus.valid_o) && n < 2000) begin
            n++;
            @(negedge clk);
        end
        if (n >= 2000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        check("out_count", n_pop, n_push);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9*PIX_W-1:0] win_from(input int v[9]);
        logic [9*PIX_W-1:0] w = '0;
        for (int i = 0; i < 9; i++) w[i*PIX_W +: PIX_W] = PIX_W'(v[i]);
        return w;
    endfunction

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int v[9];
        logic [9*PIX_W-1:0] w;
        logic [TW-1:0] th;

        bus.win_i = '0; bus.valid_i = 1'b0; bus.mode_i = '0; bus.thresh_i = '0;
        bus.bin_en_i = 1'b0; bus.user_i = '0; bus.ready_i = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid_o", int'(bus.valid_o), 0);
        check("rst_pix_o",   int'(bus.pix_o),   0);
        check("rst_user_o",  int'(bus.user_o),  0);
        check("rst_ready_o", int'(bus.ready_o), 0);
`ifdef SOBEL_DIR_EN
        check("rst_dir_o",   int'(bus.dir_o),   0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        lat_chk = 1'b1;

        // Flat window -> zero gradient.
        v = '{default: 'h40};
        send(win_from(v), 2'b00, TW'(60), 1'b0, 2'b01);
        // Strong vertical edge -> 1020, all-ones, dir 00.
        v = '{0, 0, 'hFF, 0, 0, 'hFF, 0, 0, 'hFF};
        send(win_from(v), 2'b00, TW'(60), 1'b0, 2'b10);
        // Corner impulse under each mode/binarise/threshold combination,
        // including a back-to-back mode change 00 -> 01.
        v = '{10, 0, 0, 0, 0, 0, 0, 0, 0};
        w = win_from(v);
        send(w, 2'b00, TW'(60), 1'b0, 2'b00);
        send(w, 2'b00, TW'(60), 1'b1, 2'b11);
        send(w, 2'b01, TW'(60), 1'b0, 2'b00);
        send(w, 2'b10, TW'(5),  1'b0, 2'b01);
        send(w, 2'b11, TW'(60), 1'b0, 2'b10);
        send(w, 2'b00, TW'(0),  1'b1, 2'b00);
        v = '{0, 0, 'hFF, 0, 0, 'hFF, 0, 0, 'hFF};
        send(win_from(v), 2'b00, '1, 1'b1, 2'b00);
        drain();

        // Six pixels with three cycles of backpressure mid-stream.
        lat_chk = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    for (int k = 0; k < 9; k++) v[k] = $urandom_range(0, PMAX);
                    send(win_from(v), 2'(i % 4), TW'(300), 1'b0, 2'(i));
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                bus.ready_i = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                bus.ready_i = 1'b1;
            end
        join
        drain();

        // Randomized traffic with bubbles and backpressure.
        bp_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 9; k++) begin
                case ($urandom_range(0, 3))
                    0:       v[k] = 0;
                    1:       v[k] = PMAX;
                    default: v[k] = $urandom_range(0, PMAX);
                endcase
            end
            case ($urandom_range(0, 7))
                0:       th = '0;
                1:       th = '1;
                default: th = TW'($urandom_range(0, 1200));
            endcase
            send(win_from(v), 2'($urandom_range(0, 3)), th, 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        bp_rand = 1'b0;
        bus.ready_i = 1'b1;
        @(posedge clk);
        #1;
        drain();

        // Reset with three pixels in flight: all discarded.
        lat_chk = 1'b1;
        v = '{10, 0, 0, 0, 0, 0, 0, 0, 0};
        send(win_from(v), 2'b00, TW'(60), 1'b0, 2'b01);
        send(win_from(v), 2'b01, TW'(60), 1'b0, 2'b10);
        send(win_from(v), 2'b10, TW'(60), 1'b0, 2'b11);
        rst = 1'b1;
        n_push -= q.size();
        q.delete();
        @(negedge clk);
        check("rst_mid_ready_o", int'(bus.ready_o), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid_o", int'(bus.valid_o), 0);
        check("rst_mid_pix_o",   int'(bus.pix_o),   0);
        repeat (5) @(negedge clk);
        check("rst_flush_valid_o", int'(bus.valid_o), 0);
        @(posedge clk);
        #1;
        v = '{0, 0, 'hFF, 0, 0, 'hFF, 0, 0, 'hFF};
        send(win_from(v), 2'b00, TW'(60), 1'b0, 2'b01);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
